// File: rtl/volume_port_arbiter_if.sv
// Request/status bundle between load/store clients and the volume port arbiter.
// Clients drive the master side; the arbiter owns the slave side and every status output.
interface volume_port_arbiter_if #(
    parameter int NREQ  = 2,
    parameter int LBITS = 8,
    parameter int CBITS = 15
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_dir;
    logic [NREQ*LBITS-1:0] req_len;
    logic [NREQ-1:0]       req_ready;
    logic [CBITS-1:0]      vol;
    logic                  full;
    logic                  empty;
    logic                  busy;
    logic                  done;
    logic [IDW-1:0]        done_id;
    logic [LBITS-1:0]      done_cnt;
    logic                  done_trunc;

    modport master (
        output req_valid, req_dir, req_len,
        input  req_ready, vol, full, empty, busy, done, done_id, done_cnt, done_trunc
    );

    modport slave (
        input  req_valid, req_dir, req_len,
        output req_ready, vol, full, empty, busy, done, done_id, done_cnt, done_trunc
    );
endinterface

// File: rtl/volume_port_arbiter.sv
// Round-robin owner of the shared volume counter; one fill/drain burst at a time, L+2 cycles per burst.
// Backpressure: req_ready is offered only while idle; waiting requesters hold valid/dir/len stable.
module volume_port_arbiter #(
    parameter int N     = 20000,
    parameter int CBITS = 15,
    parameter int NREQ  = 2,
    parameter int LBITS = 8
) (
    input logic                 clk,
    input logic                 rst,
    volume_port_arbiter_if.slave bus
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CBITS-1:0] VMAX = CBITS'(N);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

    state_t           state;
    logic [CBITS-1:0] vol_q;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   cur_id;
    logic [LBITS-1:0] cur_len;
    logic [LBITS-1:0] moved;
    logic             done_q;
    logic [IDW-1:0]   done_id_q;
    logic [LBITS-1:0] done_cnt_q;
    logic             trunc_q;

    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   grant_id;
    logic [IDW-1:0]   scan;
    logic             accept;
    logic             acc_dir;
    logic [LBITS-1:0] acc_len;
    logic [LBITS-1:0] moved_nxt;

    // Scan starts one past the last winner and wraps at NREQ-1 (NREQ need not be a power of two).
    always_comb begin
        grant    = '0;
        grant_id = '0;
        scan     = rr_ptr;
        if (state == IDLE && !rst) begin
            for (int k = 0; k < NREQ; k++) begin
                scan = (scan == IDW'(NREQ - 1)) ? '0 : scan + IDW'(1);
                if (grant == '0 && bus.req_valid[scan]) begin
                    grant[scan] = 1'b1;
                    grant_id    = scan;
                end
            end
        end
    end

    assign accept    = |grant;
    assign acc_dir   = bus.req_dir[grant_id];
    assign acc_len   = bus.req_len[int'(grant_id) * LBITS +: LBITS];
    assign moved_nxt = moved + LBITS'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            vol_q      <= '0;
            rr_ptr     <= IDW'(NREQ - 1);
            cur_id     <= '0;
            cur_len    <= '0;
            moved      <= '0;
            done_q     <= 1'b0;
            done_id_q  <= '0;
            done_cnt_q <= '0;
            trunc_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rr_ptr  <= grant_id;
                        cur_id  <= grant_id;
                        cur_len <= acc_len;
                        moved   <= '0;
                        // Nothing can move: report a zero-count completion right away.
                        if (acc_len == '0 || (acc_dir && vol_q == VMAX) || (!acc_dir && vol_q == '0)) begin
                            state      <= DONE;
                            done_q     <= 1'b1;
                            done_id_q  <= grant_id;
                            done_cnt_q <= '0;
                            trunc_q    <= (acc_len != '0);
                        end else begin
                            state <= acc_dir ? FILL : DRAIN;
                        end
                    end
                end
                FILL: begin
                    vol_q <= vol_q + CBITS'(1);
                    moved <= moved_nxt;
                    if (moved_nxt == cur_len || vol_q + CBITS'(1) == VMAX) begin
                        state      <= DONE;
                        done_q     <= 1'b1;
                        done_id_q  <= cur_id;
                        done_cnt_q <= moved_nxt;
                        trunc_q    <= (moved_nxt != cur_len);
                    end
                end
                DRAIN: begin
                    vol_q <= vol_q - CBITS'(1);
                    moved <= moved_nxt;
                    if (moved_nxt == cur_len || vol_q == CBITS'(1)) begin
                        state      <= DONE;
                        done_q     <= 1'b1;
                        done_id_q  <= cur_id;
                        done_cnt_q <= moved_nxt;
                        trunc_q    <= (moved_nxt != cur_len);
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    done_q     <= 1'b0;
                    done_id_q  <= '0;
                    done_cnt_q <= '0;
                    trunc_q    <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = grant;
    assign bus.vol        = vol_q;
    assign bus.full       = (vol_q == VMAX);
    assign bus.empty      = (vol_q == '0);
    assign bus.busy       = (state != IDLE);
    assign bus.done       = done_q;
    assign bus.done_id    = done_id_q;
    assign bus.done_cnt   = done_cnt_q;
    assign bus.done_trunc = trunc_q;
endmodule

// File: tb/tb_volume_port_arbiter.sv
// Bench for volume_port_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a burst-timeline model of the volume and handshake.
module tb_volume_port_arbiter;
    localparam int N     = 40;
    localparam int CBITS = 15;
    localparam int NREQ  = 3;
    localparam int LBITS = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    volume_port_arbiter_if #(.NREQ(NREQ), .LBITS(LBITS), .CBITS(CBITS)) bus ();

    volume_port_arbiter #(.N(N), .CBITS(CBITS), .NREQ(NREQ), .LBITS(LBITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: a burst accepted in cycle c moving k units shows vol0+-s in cycle c+1+s (s<=k),
    // done in cycle c+1+k, and frees the port in cycle c+2+k.
    int t_cyc = 0;
    int m_vol = 0;
    int m_rr  = NREQ - 1;
    bit b_act = 1'b0;
    int b_c, b_k, b_len, b_v0, b_id;
    bit b_dir;
    logic [NREQ-1:0] acc = '0;

    always @(negedge clk) begin
        int e_vol, s, win, ln;
        bit e_done;
        logic [NREQ-1:0] e_ready;
        t_cyc++;
        if (rst) begin
            m_vol = 0;
            b_act = 1'b0;
            m_rr  = NREQ - 1;
            acc   = '0;
            chk("rst_vol", bus.vol, 0);
            chk("rst_ready", bus.req_ready, 0);
            chk("rst_busy", bus.busy, 0);
            chk("rst_done", bus.done, 0);
            chk("rst_empty", bus.empty, 1);
            chk("rst_full", bus.full, 0);
        end else begin
            if (b_act && t_cyc >= b_c + 2 + b_k) begin
                b_act = 1'b0;
                m_vol = b_dir ? b_v0 + b_k : b_v0 - b_k;
            end
            e_vol = m_vol;
            if (b_act) begin
                s = t_cyc - (b_c + 1);
                if (s > b_k) s = b_k;
                e_vol = b_dir ? b_v0 + s : b_v0 - s;
            end
            e_done  = b_act && (t_cyc == b_c + 1 + b_k);
            e_ready = '0;
            win     = 0;
            if (!b_act) begin
                for (int k = 1; k <= NREQ; k++) begin
                    int w;
                    w = (m_rr + k) % NREQ;
                    if (e_ready == '0 && bus.req_valid[w]) begin
                        e_ready[w] = 1'b1;
                        win = w;
                    end
                end
            end
            chk("ready", bus.req_ready, e_ready);
            chk("vol", bus.vol, e_vol);
            chk("full", bus.full, (e_vol == N));
            chk("empty", bus.empty, (e_vol == 0));
            chk("busy", bus.busy, b_act);
            chk("done", bus.done, e_done);
            if (e_done) begin
                chk("done_id", bus.done_id, b_id);
                chk("done_cnt", bus.done_cnt, b_k);
                chk("done_trunc", bus.done_trunc, (b_k < b_len));
            end
            acc = bus.req_ready & bus.req_valid;
            if (e_ready != '0) begin
                ln    = int'(bus.req_len[win*LBITS +: LBITS]);
                b_act = 1'b1;
                b_c   = t_cyc;
                b_dir = bus.req_dir[win];
                b_len = ln;
                b_v0  = e_vol;
                b_id  = win;
                b_k   = b_dir ? ((ln < N - e_vol) ? ln : N - e_vol) : ((ln < e_vol) ? ln : e_vol);
                m_rr  = win;
            end
        end
    end

    // Raise a request and hold it until granted; returns cycles spent waiting for ready.
    task automatic issue(input int i, input bit d, input int len, output int waited);
        bit ok;
        ok = 1'b0;
        waited = 0;
        @(posedge clk); #1;
        bus.req_valid[i] = 1'b1;
        bus.req_dir[i]   = d;
        bus.req_len[i*LBITS +: LBITS] = LBITS'(len);
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (bus.req_ready[i] && bus.req_valid[i]) begin
                ok = 1'b1;
                waited = c;
                break;
            end
        end
        chk("issue_granted", ok, 1);
        @(posedge clk); #1;
        bus.req_valid[i] = 1'b0;
    endtask

    task automatic run(input int i, input bit d, input int len, input int ecnt, input bit etr);
        int w, lat;
        bit seen;
        issue(i, d, len, w);
        seen = 1'b0;
        lat  = 0;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                lat  = c;
                break;
            end
        end
        chk("run_done_seen", seen, 1);
        chk("run_latency", lat, ecnt + 1);
        chk("run_id", bus.done_id, i);
        chk("run_cnt", bus.done_cnt, ecnt);
        chk("run_trunc", bus.done_trunc, etr);
    endtask

    initial begin
        int w, n, seen_vol;
        int ids[4];
        int at[4];
        logic [NREQ-1:0] got;
        bit ok;
        bus.req_valid = '0;
        bus.req_dir   = '0;
        bus.req_len   = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Store 5 from reset: ready the same cycle, vol climbs 1..5, clean done.
        issue(0, 1'b1, 5, w);
        chk("s1_ready_same_cycle", w, 0);
        for (int j = 0; j <= 5; j++) begin
            @(negedge clk);
            chk("s1_vol_ramp", bus.vol, j);
        end
        chk("s1_done", bus.done, 1);
        chk("s1_done_id", bus.done_id, 0);
        chk("s1_done_cnt", bus.done_cnt, 5);
        chk("s1_done_trunc", bus.done_trunc, 0);

        // Bring vol to 3, then an oversize load truncates at empty.
        run(1, 1'b0, 2, 2, 1'b0);
        chk("s2_vol3", bus.vol, 3);
        run(1, 1'b0, 10, 3, 1'b1);
        chk("s2_empty", bus.empty, 1);

        // Two continuous single-unit stores alternate, one grant every 3 cycles.
        n = 0;
        @(posedge clk); #1;
        bus.req_dir[1:0] = 2'b11;
        bus.req_len[0 +: LBITS] = LBITS'(1);
        bus.req_len[LBITS +: LBITS] = LBITS'(1);
        bus.req_valid[1:0] = 2'b11;
        for (int c = 0; c < 60 && n < 5; c++) begin
            @(negedge clk);
            got = bus.req_ready & bus.req_valid;
            if (got != '0) begin
                if (n < 4) begin
                    ids[n] = got[1] ? 1 : 0;
                    at[n]  = c;
                end
                n++;
                @(posedge clk); #1;
                if (n >= 4) bus.req_valid = bus.req_valid & ~got;
            end
        end
        chk("s3_accepts", n, 5);
        for (int j = 0; j < 4; j++) chk("s3_alternate", ids[j], j % 2);
        for (int j = 0; j < 3; j++) chk("s3_spacing", at[j+1] - at[j], 3);
        repeat (3) @(negedge clk);
        chk("s3_vol", bus.vol, 5);

        // Near-full store truncates at N; stores at full and len=0 complete without moving.
        run(2, 1'b1, 33, 33, 1'b0);
        chk("s4_vol_n_minus_2", bus.vol, N - 2);
        run(0, 1'b1, 4, 2, 1'b1);
        chk("s4_full", bus.full, 1);
        chk("s4_vol_n", bus.vol, N);
        run(1, 1'b1, 3, 0, 1'b1);
        chk("s4_full_store_vol", bus.vol, N);
        run(2, 1'b0, 0, 0, 1'b0);
        chk("s5_len0_vol", bus.vol, N);
        run(0, 1'b0, 200, N, 1'b1);
        chk("s5_drained", bus.empty, 1);
        run(1, 1'b0, 5, 0, 1'b1);
        chk("s5_empty_load_vol", bus.vol, 0);

        // Reset in the middle of a fill drops the burst and restarts arbitration at 0.
        issue(0, 1'b1, 20, w);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.vol == 7) begin
                ok = 1'b1;
                break;
            end
        end
        chk("s6_reached_7", ok, 1);
        #2 rst = 1'b1;
        @(negedge clk);
        seen_vol = int'(bus.vol);
        chk("s6_rst_vol", seen_vol, 0);
        chk("s6_rst_busy", bus.busy, 0);
        chk("s6_rst_done", bus.done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        bus.req_dir[1:0] = 2'b11;
        bus.req_len[0 +: LBITS] = LBITS'(0);
        bus.req_len[LBITS +: LBITS] = LBITS'(0);
        bus.req_valid[1:0] = 2'b11;
        @(negedge clk);
        chk("s6_restart_ready", bus.req_ready, 3'b001);
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            bus.req_valid = bus.req_valid & ~acc;
            if (bus.req_valid == '0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("s6_both_served", ok, 1);

        // Random traffic with one asynchronous reset in the middle.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            bus.req_valid = bus.req_valid & ~acc;
            if (c == 1500) rst = 1'b1;
            if (c == 1502) rst = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                if (!bus.req_valid[i] && $urandom_range(0, 3) == 0) begin
                    bus.req_dir[i] = 1'($urandom_range(0, 1));
                    bus.req_len[i*LBITS +: LBITS] = ($urandom_range(0, 7) == 0) ?
                        LBITS'($urandom_range(0, 60)) : LBITS'($urandom_range(0, 6));
                    bus.req_valid[i] = 1'b1;
                end
            end
        end
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            bus.req_valid = bus.req_valid & ~acc;
            if (bus.req_valid == '0 && !bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("random_drain", ok, 1);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
